fwd_hazard_unit: RTL



---
 rtl/fwd_hazard_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding selects and load-use stall for an
// in-order pipeline. It keeps its own destination-tag pipeline of STAGES
// entries (stage 0 = EX, 1 = MEM, 2 = WB, ...), picks the nearest producer
// for each EX source operand, and stalls ID while a load result is not yet
// forwardable, inserting a bubble into EX.
// Optional build macro FWD_HAZARD_STATS_EN adds saturating stall_cnt/fwd_cnt.
module fwd_hazard_unit #(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned STAGES     = 3,
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned LOAD_STAGE = 2,
   parameter int unsigned SEL_W      = $clog2(STAGES)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       id_valid,
   input  logic [NUM_SRC*REG_AW-1:0]  id_rs,
   input  logic [REG_AW-1:0]          id_rd,
   input  logic                       id_reg_write,
   input  logic                       id_mem_read,
   input  logic                       flush,
   output logic                       stall,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel
`ifdef FWD_HAZARD_STATS_EN
   ,
   output logic [15:0]                stall_cnt,
   output logic [15:0]                fwd_cnt
`endif
);

   // Load flags are only consulted while the load sits inside the stall
   // window (stages 0..LOAD_STAGE-2), so deeper copies are not kept.
   localparam int unsigned LD_N = (LOAD_STAGE > 1) ? (LOAD_STAGE - 1) : 1;

   // Reject configurations whose stage numbering makes no sense.
   if (STAGES < 2 || LOAD_STAGE < 1 || LOAD_STAGE >= STAGES ||
       NUM_SRC < 1 || REG_AW < 1 || SEL_W < $clog2(STAGES)) begin : g_param_check
      $error("fwd_hazard_unit: illegal STAGES/LOAD_STAGE/NUM_SRC/REG_AW/SEL_W combination");
   end

   logic [REG_AW-1:0] tag_rd_q [STAGES];
   logic [STAGES-1:0] tag_we_q;
   logic [LD_N-1:0]   tag_ld_q;
   logic [REG_AW-1:0] ex_rs_q  [NUM_SRC];

   logic [REG_AW-1:0] tag_rd_d;
   logic              tag_we_d;
   logic              tag_ld_d;
   logic [REG_AW-1:0] ex_rs_d  [NUM_SRC];

   logic              hazard;
   logic              issue;

   // Load-use hazard: an ID source matches a not-yet-forwardable load.
   always_comb begin
      hazard = 1'b0;
      for (int unsigned s = 0; s + 1 < LOAD_STAGE; s++) begin
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (tag_ld_q[s] && tag_we_q[s] && (tag_rd_q[s] != '0) &&
                (tag_rd_q[s] == id_rs[i*REG_AW +: REG_AW])) begin
               hazard = 1'b1;
            end
         end
      end
   end

   assign stall = id_valid & ~flush & hazard;
   assign issue = id_valid & ~stall & ~flush;

   // Stage-0 next state: the issuing ID instruction, or a bubble.
   always_comb begin
      tag_rd_d = '0;
      tag_we_d = 1'b0;
      tag_ld_d = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         ex_rs_d[i] = '0;
      end
      if (issue) begin
         tag_rd_d = id_rd;
         tag_we_d = id_reg_write;
         tag_ld_d = id_mem_read;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            ex_rs_d[i] = id_rs[i*REG_AW +: REG_AW];
         end
      end
   end

   // Forward selects: scan deepest to nearest so the nearest producer wins.
   always_comb begin
      fwd_sel = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         for (int unsigned k = STAGES - 1; k >= 1; k--) begin
            if (tag_we_q[k] && (tag_rd_q[k] != '0) && (tag_rd_q[k] == ex_rs_q[i])) begin
               fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
            end
         end
      end
   end

   // Tag pipeline: shifts every cycle, stage 0 takes issue or bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            tag_rd_q[s] <= '0;
         end
         tag_we_q <= '0;
         tag_ld_q <= '0;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            ex_rs_q[i] <= '0;
         end
      end else begin
         for (int unsigned s = 1; s < STAGES; s++) begin
            tag_rd_q[s] <= tag_rd_q[s-1];
            tag_we_q[s] <= tag_we_q[s-1];
         end
         for (int unsigned s = 1; s < LD_N; s++) begin
            tag_ld_q[s] <= tag_ld_q[s-1];
         end
         tag_rd_q[0] <= tag_rd_d;
         tag_we_q[0] <= tag_we_d;
         tag_ld_q[0] <= tag_ld_d;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            ex_rs_q[i] <= ex_rs_d[i];
         end
      end
   end

`ifdef FWD_HAZARD_STATS_EN
   logic        ex_vld_q;
   logic [15:0] stall_cnt_q;
   logic [15:0] fwd_cnt_q;
   logic        fwd_any;

   assign fwd_any   = |fwd_sel;
   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;

   // Saturating event counters; ex_vld_q marks a real (non-bubble) EX entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_vld_q    <= 1'b0;
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         ex_vld_q <= issue;
         if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (fwd_any && ex_vld_q && (fwd_cnt_q != '1)) begin
            fwd_cnt_q <= fwd_cnt_q + 16'd1;
         end
      end
   end
`endif

endmodule
